// File: rtl/divide_subtract.sv
// divide_subtract
//   Iterative signed divider that undoes a multiply-add: it computes
//   Q = (N - C) / B together with the remainder. It uses a radix-2 restoring
//   algorithm and retires one quotient bit per enabled cycle. The result is
//   ready W+1 enabled edges after the accept edge (W = IN_N_WIDTH+1), or one
//   enabled edge after the accept edge when B is zero.
//
//   Optional feature macro: DIVSUB_SAT_EN
//     defined   -> Q saturates to the signed OUT_WIDTH range
//     undefined -> Q is the low OUT_WIDTH bits of the quotient (wraps)
//
//   Ports:
//     clk            clock
//     reset          synchronous active-high reset (takes priority over enable)
//     enable         global clock enable; low freezes all state and outputs
//     inReady        input-valid pulse, accepted only while idle
//     N, C           signed dividend source and offset (IN_N_WIDTH)
//     B              signed divisor (IN_D_WIDTH)
//     Q              signed quotient, registered (OUT_WIDTH)
//     REM            signed remainder, registered, takes the sign of N - C
//     outReady       one-cycle pulse when Q/REM/divByZero are valid
//     earlyOutReady  high one cycle before outReady
//     busy           high from the accept edge until the result edge
//     divByZero      registered flag that comes with the result; B was zero
module divide_subtract #(
  parameter int IN_N_WIDTH = 21,
  parameter int IN_D_WIDTH = 10,
  parameter int OUT_WIDTH  = 11
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         inReady,
  input  logic signed [IN_N_WIDTH-1:0] N,
  input  logic signed [IN_N_WIDTH-1:0] C,
  input  logic signed [IN_D_WIDTH-1:0] B,
  output logic signed [OUT_WIDTH-1:0]  Q,
  output logic signed [IN_D_WIDTH-1:0] REM,
  output logic                         outReady,
  output logic                         earlyOutReady,
  output logic                         busy,
  output logic                         divByZero
);

  localparam int W  = IN_N_WIDTH + 1;
  localparam int CW = $clog2(W);
`ifdef DIVSUB_SAT_EN
  localparam int QW = W;
`else
  // Only the low OUT_WIDTH quotient bits reach Q, so only those are kept.
  localparam int QW = OUT_WIDTH;
`endif

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t                state;
  state_t                state_next;
  logic [W-1:0]          dividend;
  logic [IN_D_WIDTH-1:0] divisor;
  logic [IN_D_WIDTH-1:0] partial;
  logic [QW-1:0]         quotient;
  logic [CW-1:0]         count;
  logic                  neg_q;
  logic                  neg_r;
  logic                  zero_div;

  logic [W-1:0]          diff;
  logic [W-1:0]          abs_diff;
  logic [IN_D_WIDTH-1:0] abs_b;
  logic [IN_D_WIDTH:0]   shifted;
  logic                  fits;
  logic [IN_D_WIDTH-1:0] reduced;
  logic [OUT_WIDTH-1:0]  q_out;
  logic [IN_D_WIDTH-1:0] rem_out;

  // D = N - C at W bits cannot overflow. The magnitude of -2^(IN_D_WIDTH-1)
  // still fits IN_D_WIDTH bits when read as unsigned.
  assign diff     = {N[IN_N_WIDTH-1], N} - {C[IN_N_WIDTH-1], C};
  assign abs_diff = diff[W-1] ? -diff : diff;
  assign abs_b    = B[IN_D_WIDTH-1] ? -B : B;

  // The partial remainder is always below |B|, so after the shift it needs
  // only one extra bit. The low bits of the difference are all that is kept.
  assign shifted = {partial, dividend[W-1]};
  assign fits    = shifted >= {1'b0, divisor};
  assign reduced = shifted[IN_D_WIDTH-1:0] - divisor;

  assign rem_out = neg_r ? -partial : partial;

`ifdef DIVSUB_SAT_EN
  logic [W-1:0] q_signed;
  assign q_signed = neg_q ? -quotient : quotient;

  always_comb begin
    q_out = q_signed[OUT_WIDTH-1:0];
    if (q_signed[W-1:OUT_WIDTH-1] != {(W-OUT_WIDTH+1){q_signed[W-1]}})
      q_out = q_signed[W-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                            : {1'b0, {(OUT_WIDTH-1){1'b1}}};
  end
`else
  assign q_out = neg_q ? -quotient : quotient;
`endif

  assign busy          = (state != IDLE);
  assign earlyOutReady = (state == FIX);

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else if (enable)
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (inReady) state_next = (B == '0) ? FIX : ITER;
      ITER:    if (count == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dividend  <= '0;
      divisor   <= '0;
      partial   <= '0;
      quotient  <= '0;
      count     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      zero_div  <= 1'b0;
      Q         <= '0;
      REM       <= '0;
      divByZero <= 1'b0;
      outReady  <= 1'b0;
    end else if (enable) begin
      outReady <= 1'b0;
      case (state)
        IDLE: begin
          if (inReady) begin
            dividend <= abs_diff;
            divisor  <= abs_b;
            partial  <= '0;
            quotient <= '0;
            count    <= CW'(W - 1);
            neg_q    <= diff[W-1] ^ B[IN_D_WIDTH-1];
            neg_r    <= diff[W-1];
            zero_div <= (B == '0);
          end
        end
        ITER: begin
          partial  <= fits ? reduced : shifted[IN_D_WIDTH-1:0];
          quotient <= {quotient[QW-2:0], fits};
          dividend <= {dividend[W-2:0], 1'b0};
          if (count != '0)
            count <= count - CW'(1);
        end
        FIX: begin
          Q         <= zero_div ? '0 : q_out;
          REM       <= zero_div ? '0 : rem_out;
          divByZero <= zero_div;
          outReady  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divide_subtract.sv
// tb_divide_subtract
//   Directed bench for divide_subtract at its default widths. Each division
//   starts at an accept edge. The bench then counts edges until outReady and
//   compares the results with hand-computed values. It also covers a stall on
//   enable, an ignored inReady pulse, a mid-operation reset and a
//   back-to-back accept.
module tb_divide_subtract;

  logic               clk;
  logic               reset;
  logic               enable;
  logic               inReady;
  logic signed [20:0] N;
  logic signed [20:0] C;
  logic signed [9:0]  B;
  logic signed [10:0] Q;
  logic signed [9:0]  REM;
  logic               outReady;
  logic               earlyOutReady;
  logic               busy;
  logic               divByZero;

  int checks   = 0;
  int failures = 0;
  int lat;
  int busyCnt;
  int acceptOut;
  int prevEarly;

  divide_subtract dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .inReady      (inReady),
    .N            (N),
    .C            (C),
    .B            (B),
    .Q            (Q),
    .REM          (REM),
    .outReady     (outReady),
    .earlyOutReady(earlyOutReady),
    .busy         (busy),
    .divByZero    (divByZero)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge, then settle before sampling or driving
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One comparison: counts it and reports any difference
  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Accept one division and run it until outReady or a 100-edge timeout.
  // Enable is held low on edges stallAt..stallAt+stallLen-1. A foreign
  // inReady pulse is raised before edge glitchAt.
  task automatic applyStimulus(input int n, input int c, input int b,
                               input int stallAt, input int stallLen,
                               input int glitchAt);
    N = 21'(n);
    C = 21'(c);
    B = 10'(b);
    inReady = 1'b1;
    enable = 1'b1;
    step;
    inReady = 1'b0;
    acceptOut = int'(outReady);
    busyCnt = busy ? 1 : 0;
    lat = 0;
    prevEarly = 0;
    for (int i = 1; i <= 100 && lat == 0; i++) begin
      enable = !(stallLen > 0 && i >= stallAt && i < stallAt + stallLen);
      if (i == glitchAt) begin
        N = 21'(7);
        C = 21'(0);
        B = 10'(1);
        inReady = 1'b1;
      end else begin
        inReady = 1'b0;
      end
      prevEarly = int'(earlyOutReady);
      step;
      if (outReady) lat = i;
      else if (busy) busyCnt++;
    end
    inReady = 1'b0;
    enable = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    inReady = 1'b0;
    N = '0;
    C = '0;
    B = '0;
    step;
    step;
    checkOutput("rst_Q", Q, 0);
    checkOutput("rst_REM", REM, 0);
    checkOutput("rst_outReady", outReady, 0);
    checkOutput("rst_early", earlyOutReady, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_dbz", divByZero, 0);
    reset = 1'b0;
    step;

    $display("[TB] 100 - (-3) over 10");
    applyStimulus(100, -3, 10, 0, 0, 0);
    checkOutput("t1_Q", Q, 10);
    checkOutput("t1_REM", REM, 3);
    checkOutput("t1_dbz", divByZero, 0);
    checkOutput("t1_latency", lat, 23);
    checkOutput("t1_busyCycles", busyCnt, 23);
    checkOutput("t1_earlyBefore", prevEarly, 1);
    checkOutput("t1_busyAfter", busy, 0);

    $display("[TB] -100 over 7");
    applyStimulus(-100, 0, 7, 0, 0, 0);
    checkOutput("t2_Q", Q, -14);
    checkOutput("t2_REM", REM, -2);

    $display("[TB] reset in the middle of a division");
    N = 21'(100);
    C = 21'(0);
    B = 10'(10);
    inReady = 1'b1;
    step;
    inReady = 1'b0;
    for (int i = 0; i < 9; i++) step;
    checkOutput("t3_busyBefore", busy, 1);
    reset = 1'b1;
    enable = 1'b0;
    step;
    checkOutput("t3_Q", Q, 0);
    checkOutput("t3_REM", REM, 0);
    checkOutput("t3_busy", busy, 0);
    checkOutput("t3_outReady", outReady, 0);
    checkOutput("t3_early", earlyOutReady, 0);
    checkOutput("t3_dbz", divByZero, 0);
    reset = 1'b0;
    enable = 1'b1;
    applyStimulus(9, 0, 3, 0, 0, 0);
    checkOutput("t3_postQ", Q, 3);
    checkOutput("t3_postREM", REM, 0);
    checkOutput("t3_postLatency", lat, 23);

    $display("[TB] back-to-back accept during outReady");
    applyStimulus(-7, 0, 2, 0, 0, 0);
    checkOutput("t4_acceptOut", acceptOut, 0);
    checkOutput("t4_Q", Q, -3);
    checkOutput("t4_REM", REM, -1);
    checkOutput("t4_latency", lat, 23);

    $display("[TB] 100 over -7");
    applyStimulus(100, 0, -7, 0, 0, 0);
    checkOutput("t5_Q", Q, -14);
    checkOutput("t5_REM", REM, 2);

    $display("[TB] divide by zero");
    applyStimulus(50, 0, 0, 0, 0, 0);
    checkOutput("t6_Q", Q, 0);
    checkOutput("t6_REM", REM, 0);
    checkOutput("t6_dbz", divByZero, 1);
    checkOutput("t6_latency", lat, 1);
    checkOutput("t6_earlyBefore", prevEarly, 1);

    $display("[TB] wide quotient");
    applyStimulus(1000000, 0, 1, 0, 0, 0);
`ifdef DIVSUB_SAT_EN
    checkOutput("t7_Q", Q, 1023);
`else
    checkOutput("t7_Q", Q, 576);
`endif
    checkOutput("t7_REM", REM, 0);
    checkOutput("t7_dbz", divByZero, 0);

    $display("[TB] inReady while busy is ignored");
    applyStimulus(100, 0, 10, 0, 0, 5);
    checkOutput("t8_Q", Q, 10);
    checkOutput("t8_REM", REM, 0);
    checkOutput("t8_latency", lat, 23);

    $display("[TB] enable stall of 5 cycles");
    applyStimulus(100, 0, 10, 8, 5, 0);
    checkOutput("t9_Q", Q, 10);
    checkOutput("t9_REM", REM, 0);
    checkOutput("t9_latency", lat, 28);
    enable = 1'b0;
    step;
    checkOutput("t9_outHold", outReady, 1);
    enable = 1'b1;
    step;
    checkOutput("t9_outDrop", outReady, 0);
    checkOutput("t9_Qhold", Q, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
